// File: rtl/io_ccff_loader.sv
// io_ccff_loader: configuration sequencer for a chain of IO tiles.
// Takes bitstream words over valid/ready and shifts them MSB first onto
// ccff_head, gating the chain with ccff_shift_en. While shifting it folds
// the bits leaving the chain on ccff_tail into a readback parity bit, and
// it counts the shifted bits.
`timescale 1ns/1ps
module io_ccff_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 20,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              rb_parity,
   output logic [CNT_W-1:0]  bit_count
);

   localparam int SUB_W = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q,  sreg_d;
   logic [SUB_W-1:0]  sub_q,   sub_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              par_q,   par_d;

   // State register and datapath registers, synchronous active-low reset.
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         sub_q   <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         sub_q   <= sub_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

   // Next-state logic. An abort wins over everything and leaves the counter
   // and parity at their current values.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  cnt_d   = '0;
                  par_d   = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FETCH: begin
               if (word_valid) begin
                  sreg_d  = word_data;
                  sub_d   = SUB_W'(WORD_W);
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_SHIFT: begin
               par_d  = par_q ^ ccff_tail;
               sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
               cnt_d  = cnt_q + CNT_W'(1);
               sub_d  = sub_q - SUB_W'(1);
               // The chain length check comes first: when the chain is full,
               // any bits left in the current word are dropped.
               if (cnt_q + CNT_W'(1) == CNT_W'(CHAIN_LEN)) begin
                  state_d = S_DONE;
               end else if (sub_q == SUB_W'(1)) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = S_SHIFT;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Outputs decoded from registered state. Handshake and shift enable are
   // gated by abort, so an aborting cycle neither accepts a word nor advances
   // the chain.
   always_comb begin
      word_ready    = (state_q == S_FETCH) && !abort;
      ccff_shift_en = (state_q == S_SHIFT) && !abort;
      ccff_head     = (state_q == S_SHIFT) && sreg_q[WORD_W-1];
      busy          = (state_q == S_FETCH) || (state_q == S_SHIFT);
      done          = (state_q == S_DONE);
      rb_parity     = par_q;
      bit_count     = cnt_q;
   end

endmodule

// File: tb/tb_io_ccff_loader.sv
// Testbench for io_ccff_loader. It uses a 20-bit chain instance and a 3-bit
// chain instance. Each instance has a behavioural chain model that feeds
// ccff_tail. A queue holds the expected head bits: bits are pushed when a
// word is accepted and popped on every shift-enable cycle.
`timescale 1ns/1ps
module tb_io_ccff_loader;

   typedef struct {
      logic [7:0]  w0, w1, w2;
      int          stall;
      logic [19:0] pre;
      bit          poke;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, wvalid;
   logic [7:0]  wdata;
   logic        wready, head, sen, tail, busy, done, par;
   logic [15:0] bcnt;
   logic        start3, wvalid3;
   logic [7:0]  wdata3;
   logic        wready3, head3, sen3, tail3, busy3, done3, par3;
   logic [15:0] bcnt3;

   logic [19:0] chain, pre_val;
   logic [2:0]  chain3, pre_val3;
   logic        load_chain;
   logic        q_bits[$];
   int          n_vec = 0;
   int          n_err = 0;
   vec_t        vecs[4];

   always #5 clk = ~clk;

   io_ccff_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) u_dut (
      .prog_clk(clk), .prog_reset_n(rst_n), .start(start), .abort(abort),
      .word_data(wdata), .word_valid(wvalid), .word_ready(wready),
      .ccff_head(head), .ccff_shift_en(sen), .ccff_tail(tail),
      .busy(busy), .done(done), .rb_parity(par), .bit_count(bcnt));

   io_ccff_loader #(.WORD_W(8), .CHAIN_LEN(3), .CNT_W(16)) u_dut3 (
      .prog_clk(clk), .prog_reset_n(rst_n), .start(start3), .abort(abort),
      .word_data(wdata3), .word_valid(wvalid3), .word_ready(wready3),
      .ccff_head(head3), .ccff_shift_en(sen3), .ccff_tail(tail3),
      .busy(busy3), .done(done3), .rb_parity(par3), .bit_count(bcnt3));

   // Chain models: preload on request, otherwise advance on shift enable.
   always @(posedge clk) begin
      if (load_chain) begin
         chain  <= pre_val;
         chain3 <= pre_val3;
      end else begin
         if (sen)  chain  <= {chain[18:0], head};
         if (sen3) chain3 <= {chain3[1:0], head3};
      end
   end
   assign tail  = chain[19];
   assign tail3 = chain3[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   // Runs one complete 20-bit load and checks it against the scoreboard.
   task automatic run_load(input vec_t v, input string nm);
      int   idx = 0, pushed = 0, shifts = 0, readies = 0, dones = 0, cyc = 0;
      int   stall_left;
      logic exp_par, collide, idle_bad;
      stall_left = v.stall;
      collide    = 1'b0;
      idle_bad   = 1'b0;
      q_bits.delete();
      @(negedge clk); pre_val = v.pre; load_chain = 1'b1;
      @(negedge clk); load_chain = 1'b0; exp_par = ^v.pre; start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (dones == 0 && cyc < 300) begin
         wvalid = (idx < 3) && !(idx == 1 && stall_left > 0);
         wdata  = (idx == 0) ? v.w0 : (idx == 1) ? v.w1 : v.w2;
         if (v.poke) start = (shifts == 4 || shifts == 20);
         #1;
         if (cyc == 0) begin
            chk({nm, " clear"}, bcnt, 32'd0);
            chk({nm, " busy"}, busy, 32'd1);
         end
         if (wready && wvalid) begin
            for (int b = 7; b >= 0; b--) begin
               if (pushed < 20) begin
                  q_bits.push_back(wdata[b]);
                  pushed++;
               end
            end
            idx++;
            readies++;
         end else if (wready && stall_left > 0) begin
            stall_left--;
         end
         if (wready && sen) collide = 1'b1;
         if (sen) begin
            if (q_bits.size() == 0) fail_now({nm, " extra shift"});
            else chk({nm, " head"}, head, q_bits.pop_front());
            shifts++;
         end
         if (done) dones++;
         @(negedge clk);
         cyc++;
      end
      start  = 1'b0;
      wvalid = 1'b0;
      if (dones == 0) fail_now({nm, " timeout waiting for done"});
      #1;
      chk({nm, " shifts"}, shifts, 32'd20);
      chk({nm, " readies"}, readies, 32'd3);
      chk({nm, " bit_count"}, bcnt, 32'd20);
      chk({nm, " rb_parity"}, par, exp_par);
      chk({nm, " leftover"}, q_bits.size(), 32'd0);
      chk({nm, " ready with shift"}, collide, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (busy || done || sen || wready) idle_bad = 1'b1;
      end
      chk({nm, " idle after done"}, idle_bad, 32'd0);
   endtask

   // Starts a 20-bit load of A5,3C and stops once n shifts have been seen.
   task automatic shift_n(input int n);
      int idx = 0, shifts = 0, cyc = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (shifts < n && cyc < 100) begin
         wvalid = 1'b1;
         wdata  = (idx == 0) ? 8'hA5 : 8'h3C;
         #1;
         if (wready && wvalid) idx++;
         if (sen) shifts++;
         @(negedge clk);
         cyc++;
      end
      wvalid = 1'b0;
      if (shifts < n) fail_now("timeout waiting for shifts");
   endtask

   initial begin
      logic bad;
      int   s3, r3, d3;
      vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 0,  20'hFFFFF, 1'b0};
      vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 10, 20'hFFFFF, 1'b0};
      vecs[2] = '{8'h00, 8'hFF, 8'h81, 0,  20'h12345, 1'b1};
      vecs[3] = '{8'h5A, 8'hC3, 8'h0F, 3,  20'h00001, 1'b0};
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; wvalid = 1'b0; wdata = 8'h00;
      start3 = 1'b0; wvalid3 = 1'b0; wdata3 = 8'h00;
      load_chain = 1'b0; pre_val = 20'h0; pre_val3 = 3'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset outputs", {wready, head, sen, busy, done, par, bcnt}, 32'd0);
      chk("reset outputs chain3", {wready3, head3, sen3, busy3, done3, par3, bcnt3}, 32'd0);

      for (int i = 0; i < 4; i++) run_load(vecs[i], $sformatf("vec%0d", i));

      // start together with abort in IDLE: must stay IDLE with bit_count kept
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      #1;
      chk("start+abort busy", busy, 32'd0);
      chk("start+abort ready", wready, 32'd0);
      chk("start+abort bit_count", bcnt, 32'd20);

      // reset after 5 shifts
      shift_n(5);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("midreset outputs", {wready, head, sen, busy, done, par, bcnt}, 32'd0);
      bad = 1'b0;
      wvalid = 1'b1; wdata = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (sen || busy) bad = 1'b1;
      end
      wvalid = 1'b0;
      chk("midreset quiet", bad, 32'd0);

      // abort after 12 shifts
      shift_n(12);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #1;
      chk("abort busy", busy, 32'd0);
      chk("abort shift_en", sen, 32'd0);
      chk("abort ready", wready, 32'd0);
      chk("abort bit_count", bcnt, 32'd12);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (done || busy) bad = 1'b1;
      end
      chk("abort no done", bad, 32'd0);
      run_load(vecs[0], "reload");

      // CHAIN_LEN=3 with word E1
      q_bits.delete();
      s3 = 0; r3 = 0; d3 = 0;
      @(negedge clk); pre_val3 = 3'b100; load_chain = 1'b1;
      @(negedge clk); load_chain = 1'b0; start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      wvalid3 = 1'b1; wdata3 = 8'hE1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (wready3 && wvalid3) begin
            r3++;
            for (int b = 7; b >= 5; b--) q_bits.push_back(wdata3[b]);
         end
         if (sen3) begin
            if (q_bits.size() == 0) fail_now("short head extra shift");
            else chk("short head", head3, q_bits.pop_front());
            s3++;
         end
         if (done3) d3++;
         @(negedge clk);
      end
      wvalid3 = 1'b0;
      #1;
      chk("short shifts", s3, 32'd3);
      chk("short readies", r3, 32'd1);
      chk("short dones", d3, 32'd1);
      chk("short bit_count", bcnt3, 32'd3);
      chk("short rb_parity", par3, 32'd1);
      chk("short leftover", q_bits.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
